// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM shadow-register controller: channel FSM
// encoding, register map and reset defaults.
package pwm_pkg;

    localparam int WORD_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } chan_state_e;

    localparam logic [6:0] PWM_CTRL_REG  = 7'd21;
    localparam logic [6:0] PWM_ENB_REG   = 7'd22;
    localparam logic [6:0] PWM_FREQ_BASE = 7'd23;
    localparam logic [6:0] PWM_DUTY_BASE = 7'd49;

    localparam logic [WORD_W-1:0] PWM_DEFAULT_FREQ = 16'd50000;
    localparam logic [WORD_W-1:0] PWM_DEFAULT_DUTY = 16'd0;

    // A duty longer than the period saturates at 100 %.
    function automatic logic [WORD_W-1:0] clip_duty(input logic [WORD_W-1:0] freq,
                                                    input logic [WORD_W-1:0] duty);
        return (duty > freq) ? freq : duty;
    endfunction

endpackage

// File: rtl/pwm_shadow_ctrl_if.sv
// Register-write bus from the SPI state machine into the PWM shadow controller.
interface pwm_shadow_ctrl_if;
    logic       wr_stb;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;

    modport master (output wr_stb, output wr_addr, output wr_data);
    modport slave  (input  wr_stb, input  wr_addr, input  wr_data);
endinterface

// File: rtl/pwm_shadow_chan.sv
// One PWM channel: byte-wise staging registers, IDLE/ARMED/COMMIT FSM and the
// validated live frequency/duty words.
module pwm_shadow_chan
    import pwm_pkg::*;
#(
    parameter logic [WORD_W-1:0] DEFAULT_FREQ = PWM_DEFAULT_FREQ,
    parameter logic [WORD_W-1:0] DEFAULT_DUTY = PWM_DEFAULT_DUTY
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_freq_lo_i,
    input  logic              wr_freq_hi_i,
    input  logic              wr_duty_lo_i,
    input  logic              wr_duty_hi_i,
    input  logic [7:0]        wr_data_i,
    input  logic              period_end_i,
    input  logic              run_i,
    input  logic              err_clr_i,
    output logic [WORD_W-1:0] freq_o,
    output logic [WORD_W-1:0] duty_o,
    output logic              pending_o,
    output logic              err_o
);

    chan_state_e       state_q, state_d;
    logic [WORD_W-1:0] stg_freq_q, stg_freq_d;
    logic [WORD_W-1:0] stg_duty_q, stg_duty_d;
    logic [WORD_W-1:0] freq_q, freq_d;
    logic [WORD_W-1:0] duty_q, duty_d;
    logic              err_q, err_d;
    logic              hi_wr;
    logic              commit_err;

    assign hi_wr = wr_freq_hi_i | wr_duty_hi_i;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            stg_freq_q <= DEFAULT_FREQ;
            stg_duty_q <= DEFAULT_DUTY;
            freq_q     <= DEFAULT_FREQ;
            duty_q     <= DEFAULT_DUTY;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stg_freq_q <= stg_freq_d;
            stg_duty_q <= stg_duty_d;
            freq_q     <= freq_d;
            duty_q     <= duty_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        stg_freq_d = stg_freq_q;
        stg_duty_d = stg_duty_q;
        freq_d     = freq_q;
        duty_d     = duty_q;
        commit_err = 1'b0;

        if (wr_freq_lo_i) stg_freq_d[7:0]  = wr_data_i;
        if (wr_freq_hi_i) stg_freq_d[15:8] = wr_data_i;
        if (wr_duty_lo_i) stg_duty_d[7:0]  = wr_data_i;
        if (wr_duty_hi_i) stg_duty_d[15:8] = wr_data_i;

        case (state_q)
            ST_IDLE: begin
                if (hi_wr) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                // A stopped channel has no period boundary to wait for.
                if (period_end_i || !run_i) state_d = ST_COMMIT;
            end
            ST_COMMIT: begin
                // Commit uses the pre-edge staging; a byte landing now waits for the next commit.
                state_d = hi_wr ? ST_ARMED : ST_IDLE;
                if (stg_freq_q == '0) begin
                    commit_err = 1'b1;
                end else begin
                    freq_d     = stg_freq_q;
                    duty_d     = clip_duty(stg_freq_q, stg_duty_q);
                    commit_err = (stg_duty_q > stg_freq_q);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        err_d = err_q;
        if (commit_err)     err_d = 1'b1;
        else if (err_clr_i) err_d = 1'b0;
    end

    assign freq_o    = freq_q;
    assign duty_o    = duty_q;
    assign pending_o = (state_q != ST_IDLE);
    assign err_o     = err_q;

endmodule

// File: rtl/pwm_shadow_ctrl.sv
// PWM shadow controller: decodes SPI register writes into control bits and
// per-channel staging writes, and owns the live words fed to the generators.
module pwm_shadow_ctrl
    import pwm_pkg::*;
#(
    parameter int                NUM_CH       = 2,
    parameter logic [6:0]        CTRL_REG     = PWM_CTRL_REG,
    parameter logic [6:0]        ENB_REG      = PWM_ENB_REG,
    parameter logic [6:0]        FREQ_BASE    = PWM_FREQ_BASE,
    parameter logic [6:0]        DUTY_BASE    = PWM_DUTY_BASE,
    parameter logic [WORD_W-1:0] DEFAULT_FREQ = PWM_DEFAULT_FREQ,
    parameter logic [WORD_W-1:0] DEFAULT_DUTY = PWM_DEFAULT_DUTY
) (
    input  logic                     clk,
    input  logic                     reset,
    pwm_shadow_ctrl_if.slave         wr_bus,
    input  logic [NUM_CH-1:0]        period_end,
    input  logic                     err_clr,
    output logic [NUM_CH-1:0]        pwm_on,
    output logic                     pwm_enb,
    output logic [WORD_W*NUM_CH-1:0] freq_out,
    output logic [WORD_W*NUM_CH-1:0] duty_out,
    output logic [NUM_CH-1:0]        commit_pending,
    output logic [NUM_CH-1:0]        update_err
);

    logic [NUM_CH-1:0] pwm_on_q, pwm_on_d;
    logic              pwm_enb_q, pwm_enb_d;
    logic [NUM_CH-1:0] wr_freq_lo, wr_freq_hi, wr_duty_lo, wr_duty_hi;
    logic [NUM_CH-1:0] run;

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_on_q  <= '0;
            pwm_enb_q <= 1'b0;
        end else begin
            pwm_on_q  <= pwm_on_d;
            pwm_enb_q <= pwm_enb_d;
        end
    end

    always_comb begin
        pwm_on_d  = pwm_on_q;
        pwm_enb_d = pwm_enb_q;
        if (wr_bus.wr_stb && (wr_bus.wr_addr == CTRL_REG)) pwm_on_d  = wr_bus.wr_data[NUM_CH-1:0];
        if (wr_bus.wr_stb && (wr_bus.wr_addr == ENB_REG))  pwm_enb_d = wr_bus.wr_data[7];
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_chan
            assign wr_freq_lo[gi] = wr_bus.wr_stb && (wr_bus.wr_addr == FREQ_BASE + 7'(2*gi));
            assign wr_freq_hi[gi] = wr_bus.wr_stb && (wr_bus.wr_addr == FREQ_BASE + 7'(2*gi+1));
            assign wr_duty_lo[gi] = wr_bus.wr_stb && (wr_bus.wr_addr == DUTY_BASE + 7'(2*gi));
            assign wr_duty_hi[gi] = wr_bus.wr_stb && (wr_bus.wr_addr == DUTY_BASE + 7'(2*gi+1));
            assign run[gi]        = pwm_on_q[gi] & pwm_enb_q;

            pwm_shadow_chan #(
                .DEFAULT_FREQ (DEFAULT_FREQ),
                .DEFAULT_DUTY (DEFAULT_DUTY)
            ) u_chan (
                .clk          (clk),
                .reset        (reset),
                .wr_freq_lo_i (wr_freq_lo[gi]),
                .wr_freq_hi_i (wr_freq_hi[gi]),
                .wr_duty_lo_i (wr_duty_lo[gi]),
                .wr_duty_hi_i (wr_duty_hi[gi]),
                .wr_data_i    (wr_bus.wr_data),
                .period_end_i (period_end[gi]),
                .run_i        (run[gi]),
                .err_clr_i    (err_clr),
                .freq_o       (freq_out[WORD_W*gi +: WORD_W]),
                .duty_o       (duty_out[WORD_W*gi +: WORD_W]),
                .pending_o    (commit_pending[gi]),
                .err_o        (update_err[gi])
            );
        end
    endgenerate

    assign pwm_on  = pwm_on_q;
    assign pwm_enb = pwm_enb_q;

endmodule

// File: tb/tb_pwm_shadow_ctrl.sv
// Bench for pwm_shadow_ctrl: directed register sequences plus random traffic,
// all compared each cycle against a transaction-level model of the controller.
module tb_pwm_shadow_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  period_end;
    logic        err_clr;
    logic [1:0]  pwm_on;
    logic        pwm_enb;
    logic [31:0] freq_out;
    logic [31:0] duty_out;
    logic [1:0]  commit_pending;
    logic [1:0]  update_err;

    int n_total = 0;
    int n_pass  = 0;
    bit verbose = 1'b1;

    pwm_shadow_ctrl_if bus ();

    pwm_shadow_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .wr_bus         (bus),
        .period_end     (period_end),
        .err_clr        (err_clr),
        .pwm_on         (pwm_on),
        .pwm_enb        (pwm_enb),
        .freq_out       (freq_out),
        .duty_out       (duty_out),
        .commit_pending (commit_pending),
        .update_err     (update_err)
    );

    always #5 clk = ~clk;

    // Reference model state
    logic [15:0] m_stg_f [2];
    logic [15:0] m_stg_d [2];
    logic [15:0] m_f     [2];
    logic [15:0] m_d     [2];
    bit          m_pend  [2];
    bit          m_due   [2];
    bit          m_err   [2];
    logic [1:0]  m_on;
    bit          m_enb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", tag, got, exp, $time);
        else n_pass++;
    endtask

    task automatic model_step();
        if (reset) begin
            for (int c = 0; c < 2; c++) begin
                m_stg_f[c] = 16'd50000; m_stg_d[c] = 16'd0;
                m_f[c]     = 16'd50000; m_d[c]     = 16'd0;
                m_pend[c] = 0; m_due[c] = 0; m_err[c] = 0;
            end
            m_on = 2'b00; m_enb = 0;
            return;
        end
        for (int c = 0; c < 2; c++) begin
            bit hi_wr, stopped, set_err;
            logic [15:0] sf, sd;
            hi_wr   = bus.wr_stb && ((int'(bus.wr_addr) == 24 + 2*c) || (int'(bus.wr_addr) == 50 + 2*c));
            stopped = !(m_on[c] && m_enb);
            sf = m_stg_f[c];
            sd = m_stg_d[c];
            set_err = 0;
            if (m_due[c]) begin
                if (sf == 0) set_err = 1;
                else begin
                    m_f[c] = sf;
                    if (sd > sf) begin m_d[c] = sf; set_err = 1; end
                    else m_d[c] = sd;
                end
                m_due[c]  = 0;
                m_pend[c] = hi_wr;
            end else if (m_pend[c]) begin
                if (period_end[c] || stopped) m_due[c] = 1;
            end else if (hi_wr) begin
                m_pend[c] = 1;
            end
            if (set_err) m_err[c] = 1;
            else if (err_clr) m_err[c] = 0;
            if (bus.wr_stb) begin
                if (int'(bus.wr_addr) == 23 + 2*c) m_stg_f[c][7:0]  = bus.wr_data;
                if (int'(bus.wr_addr) == 24 + 2*c) m_stg_f[c][15:8] = bus.wr_data;
                if (int'(bus.wr_addr) == 49 + 2*c) m_stg_d[c][7:0]  = bus.wr_data;
                if (int'(bus.wr_addr) == 50 + 2*c) m_stg_d[c][15:8] = bus.wr_data;
            end
        end
        if (bus.wr_stb && bus.wr_addr == 7'd21) m_on  = bus.wr_data[1:0];
        if (bus.wr_stb && bus.wr_addr == 7'd22) m_enb = bus.wr_data[7];
    endtask

    task automatic compare_all();
        chk("freq0",   {16'h0, freq_out[15:0]},  {16'h0, m_f[0]});
        chk("freq1",   {16'h0, freq_out[31:16]}, {16'h0, m_f[1]});
        chk("duty0",   {16'h0, duty_out[15:0]},  {16'h0, m_d[0]});
        chk("duty1",   {16'h0, duty_out[31:16]}, {16'h0, m_d[1]});
        chk("pwm_on",  {30'h0, pwm_on},          {30'h0, m_on});
        chk("pwm_enb", {31'h0, pwm_enb},         {31'h0, m_enb});
        chk("pending", {30'h0, commit_pending},  {30'h0, m_pend[1], m_pend[0]});
        chk("err",     {30'h0, update_err},      {30'h0, m_err[1], m_err[0]});
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic wr(input logic [6:0] addr, input logic [7:0] data);
        bus.wr_stb  = 1'b1;
        bus.wr_addr = addr;
        bus.wr_data = data;
        if (verbose) $display("wr addr=%0d data=0x%02h pe=%b t=%0t", addr, data, period_end, $time);
        step();
        bus.wr_stb = 1'b0;
    endtask

    task automatic pulse_pe(input logic [1:0] pe);
        period_end = pe;
        if (verbose) $display("period_end=%b t=%0t", pe, $time);
        step();
        period_end = 2'b00;
    endtask

    initial begin
        reset = 1'b1; period_end = 2'b00; err_clr = 1'b0;
        bus.wr_stb = 1'b0; bus.wr_addr = '0; bus.wr_data = '0;
        m_on = 2'b00; m_enb = 0;
        step(); step();
        reset = 1'b0;
        step();
        chk("rst_freq0", {16'h0, freq_out[15:0]}, 32'd50000);
        chk("rst_duty",  duty_out, 32'd0);
        chk("rst_on",    {30'h0, pwm_on}, 32'd0);
        chk("rst_enb",   {31'h0, pwm_enb}, 32'd0);
        chk("rst_pend",  {30'h0, commit_pending}, 32'd0);

        // Duty update on a running channel waits for period_end
        wr(7'd21, 8'h03);
        wr(7'd22, 8'h80);
        wr(7'd49, 8'h10);
        wr(7'd50, 8'h27);
        for (int i = 0; i < 100; i++) step();
        chk("hold_pend", {31'h0, commit_pending[0]}, 32'd1);
        chk("hold_duty", {16'h0, duty_out[15:0]}, 32'd0);
        pulse_pe(2'b01);
        chk("lat1_duty", {16'h0, duty_out[15:0]}, 32'd0);
        step();
        chk("lat2_duty", {16'h0, duty_out[15:0]}, 32'h2710);
        chk("lat2_pend", {31'h0, commit_pending[0]}, 32'd0);

        // Stopped channel commits without period_end
        wr(7'd21, 8'h01);
        wr(7'd25, 8'h88);
        wr(7'd26, 8'h13);
        step(); step();
        chk("idle_freq1", {16'h0, freq_out[31:16]}, 32'h1388);

        // Zero frequency is rejected
        wr(7'd23, 8'h00);
        wr(7'd24, 8'h00);
        pulse_pe(2'b01);
        step();
        chk("zero_freq0", {16'h0, freq_out[15:0]}, 32'd50000);
        chk("zero_err0",  {31'h0, update_err[0]}, 32'd1);
        err_clr = 1'b1; step(); err_clr = 1'b0;
        chk("clr_err0",   {31'h0, update_err[0]}, 32'd0);

        // Duty longer than period is clipped
        wr(7'd23, 8'hE8); wr(7'd24, 8'h03);
        wr(7'd49, 8'hD0); wr(7'd50, 8'h07);
        pulse_pe(2'b01);
        step();
        chk("clip_duty0", {16'h0, duty_out[15:0]}, 32'd1000);
        chk("clip_freq0", {16'h0, freq_out[15:0]}, 32'd1000);
        chk("clip_err0",  {31'h0, update_err[0]}, 32'd1);
        err_clr = 1'b1; step(); err_clr = 1'b0;

        // High byte with period_end, then another during COMMIT
        wr(7'd23, 8'h00); wr(7'd24, 8'hF0); wr(7'd49, 8'h10);
        period_end = 2'b01;
        wr(7'd50, 8'h05);
        period_end = 2'b00;
        wr(7'd50, 8'h06);
        chk("simul_duty0", {16'h0, duty_out[15:0]}, 32'h0510);
        chk("simul_freq0", {16'h0, freq_out[15:0]}, 32'hF000);
        chk("simul_pend0", {31'h0, commit_pending[0]}, 32'd1);
        pulse_pe(2'b01);
        step();
        chk("next_duty0", {16'h0, duty_out[15:0]}, 32'h0610);

        // Random traffic
        verbose = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            int r;
            logic [6:0] addrs [10];
            addrs = '{7'd21, 7'd22, 7'd23, 7'd24, 7'd25, 7'd26, 7'd49, 7'd50, 7'd51, 7'd52};
            r = int'($urandom_range(0, 99));
            bus.wr_stb  = (r < 40);
            bus.wr_addr = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127))
                                                      : addrs[$urandom_range(0, 9)];
            bus.wr_data = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(0, 255));
            period_end  = {($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0)};
            err_clr     = ($urandom_range(0, 19) == 0);
            reset       = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0; bus.wr_stb = 1'b0; period_end = 2'b00; err_clr = 1'b0;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pwm_shadow_ctrl.md
Name: pwm_shadow_ctrl

Overview:
- Sits between the SPI register-write path and the PWM channel generators; owns the live frequency/duty words driven into each channel.
- Captures SPI byte writes into per-channel shadow (staging) registers.
- Commits them atomically, so a 16-bit frequency or duty never changes mid-period or half-written.
- Also owns the channel-on/global-enable control bits and reports commit status per channel.

Parameters:
- NUM_CH, 2, number of PWM channels served
- CTRL_REG, 7'd21, address of channel-on register (bit i = channel i on)
- ENB_REG, 7'd22, address of global-enable register (bit 7 = pwm_enb)
- FREQ_BASE, 7'd23, channel i freq low byte at FREQ_BASE+2i, high byte at FREQ_BASE+2i+1
- DUTY_BASE, 7'd49, channel i duty low/high at DUTY_BASE+2i / DUTY_BASE+2i+1
- DEFAULT_FREQ, 16'd50000, period in clk cycles after reset (1 kHz at 50 MHz)
- DEFAULT_DUTY, 16'd0, duty in clk cycles after reset

Ports:
- clk  in  1  system clock (50 MHz clk_core)
- reset  in  1  synchronous, active-high reset
- wr_stb  in  1  one-cycle register-write strobe from SPI state machine
- wr_addr  in  7  register address of write
- wr_data  in  8  register data of write
- period_end  in  NUM_CH  one-cycle pulse from channel i at last cycle of its period
- pwm_on  out  NUM_CH  per-channel enable to PWM generators
- pwm_enb  out  1  global PWM enable
- freq_out  out  16*NUM_CH  live period word, channel i at [16i+15:16i]
- duty_out  out  16*NUM_CH  live duty word, same packing
- commit_pending  out  NUM_CH  channel has staged data awaiting commit
- update_err  out  NUM_CH  sticky: a commit was rejected or clipped
- err_clr  in  1  one-cycle pulse clears all update_err bits

Behaviour:
- Reset (sync, active-high, overrides all inputs):
  - freq_out = DEFAULT_FREQ and duty_out = DEFAULT_DUTY for all channels.
  - Staging registers are loaded with the same default values.
  - pwm_on = 0, pwm_enb = 0, commit_pending = 0, update_err = 0; all channel FSMs go to IDLE.
- Reset mid-operation discards staged data.
- Control writes:
  - wr_stb with wr_addr == CTRL_REG: pwm_on <= wr_data[NUM_CH-1:0] on the next edge.
  - wr_stb with wr_addr == ENB_REG: pwm_enb <= wr_data[7] on the next edge.
  - Control writes take no commit path.
- Staging writes:
  - A low-byte address writes the staging low byte only. It does not arm the channel.
  - A high-byte address writes the staging high byte and arms the channel (freq or duty high byte).
  - Repeated writes before a commit overwrite staging; the last value wins.
- Writes to unrelated addresses are ignored.
- Per-channel FSM, IDLE -> ARMED -> COMMIT -> IDLE:
  - IDLE: a high-byte write moves the channel to ARMED; commit_pending[i] = 1 from the next cycle.
  - ARMED:
    - Moves to COMMIT when period_end[i] = 1, or when pwm_on[i] = 0, or when pwm_enb = 0 (an idle channel updates immediately).
    - Further writes while ARMED stay in ARMED.
  - COMMIT (exactly one cycle): freq_out/duty_out load from staging at the end of this cycle. commit_pending[i] clears at the same edge. Next state is IDLE.
  - A high-byte write in COMMIT goes to ARMED instead of IDLE. The new byte is not part of this commit; it waits for the next commit.
- Latency: period_end sampled at edge N -> COMMIT during cycle N+1 -> new outputs visible from edge N+2. Maximum 2 cycles; the generator latches on its next period start.
- Simultaneous events:
  - A high-byte write on the same cycle period_end is sampled in ARMED: the commit proceeds, and the staged value includes that byte (staging is written at the same edge).
  - period_end while IDLE is ignored.
- Validation at COMMIT:
  - Staged freq == 0: commit is rejected. Outputs keep their old values, update_err[i] <= 1, FSM returns to IDLE.
  - Staged duty > staged freq: duty_out = freq (clip to 100%) and update_err[i] <= 1.
- Error flags:
  - update_err is sticky until err_clr.
  - If err_clr and a new error occur in the same cycle, the set wins.
- Channels are fully independent; no arbitration between them is needed.

Decomposition:
- Shared package pwm_pkg holds:
  - FSM state encoding: ST_IDLE, ST_ARMED, ST_COMMIT (2 bits).
  - Register address constants for CTRL/ENB/FREQ/DUTY bases.
  - The 16-bit word width constant.
- Sub-module pwm_shadow_chan: one channel's staging registers, FSM, validation and live outputs.
  - The top generates NUM_CH instances and decodes addresses into per-channel write enables.

Test Plan:
- Reset release -> freq_out[15:0] = 50000, duty_out = 0, pwm_on = 0, pwm_enb = 0, commit_pending = 0.
- Sequence:
  - Stimulus: pwm_on = 1, pwm_enb = 1; write duty ch0 addr 49 = 0x10, addr 50 = 0x27.
  - Required response: commit_pending[0] = 1 and duty_out[15:0] stays 0 for 100 cycles; pulse period_end[0] -> duty_out[15:0] = 0x2710 exactly 2 cycles later, commit_pending[0] = 0.
- With pwm_on[1] = 0: write freq ch1 addr 25 = 0x88, addr 26 = 0x13 -> freq_out[31:16] = 0x1388 within 2 cycles of the high-byte write, with no period_end pulse.
- Write freq ch0 = 0 (addr 23 = 0, addr 24 = 0), then period_end[0] -> freq_out unchanged, update_err[0] = 1; err_clr -> update_err[0] = 0.
- Staged freq = 1000, duty = 2000 on ch0, then commit -> duty_out[15:0] = 1000, update_err[0] = 1.
- Write high byte on the same cycle as period_end[0] in ARMED -> committed value includes the new byte. Then high-byte write during COMMIT -> FSM ends in ARMED and commit_pending[0] = 1.
